step_controller: RTL and testbench
==================================

Name: step_controller

Overview:
- Parametrised front-panel step/clock controller for the RISC top level. It replaces the use of raw KEY[0] as the CPU clock.
- Synchronises and debounces NUM_KEYS active-low push buttons and produces clean one-cycle press pulses.
- Drives a single-cycle CPU step enable (step_en) in one of four modes: single-step, burst, free-run, halt.
- The CPU runs on CLOCK_50 and advances only when step_en=1.

Parameters:
- NUM_KEYS, 4, number of push buttons handled.
- STEP_KEY, 0, index of the key that triggers steps.
- DEBOUNCE_CYCLES, 500000, stable cycles required to accept a new key level (10 ms at 50 MHz). Benches override it to 4.
- BURST_W, 8, width of burst_len.
- DIV_W, 26, width of run_div.
- COUNT_W, 16, width of step_count.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- key_n  in  NUM_KEYS  raw asynchronous buttons, 0 = pressed.
- mode  in  2  00 SINGLE, 01 BURST, 10 RUN, 11 HALT.
- burst_len  in  BURST_W  steps per press in BURST mode.
- run_div  in  DIV_W  RUN mode period minus 1, in cycles.
- key_level  out  NUM_KEYS  debounced level, 1 = pressed.
- key_press  out  NUM_KEYS  one-cycle pulse on debounced press edge.
- step_en  out  1  one-cycle CPU advance enable.
- busy  out  1  high while a burst is in progress or RUN is active.
- step_count  out  COUNT_W  number of step_en pulses since reset.

Behaviour:
- Single clock, CLOCK_50. Reset is synchronous and active-low on reset_n, sampled at the rising edge. All state is clocked by CLOCK_50.
- Reset values:
  - key_level, key_press, step_en, busy, step_count all 0.
  - Synchroniser flops preset to released (1).
  - Debounce counters 0.
  - FSM in IDLE.
- Reset mid-burst or mid-run aborts immediately. There is no step_en in the cycle after reset deasserts.
- Per-key pipeline:
  - 2-flop synchroniser, then a debounce counter.
  - When the synced value differs from key_level, the counter increments. Any cycle where it equals key_level clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1, key_level toggles and the counter clears.
  - key_press = 1 for exactly the cycle after key_level goes 0->1. Releases produce no pulse.
- Latency: a clean press at raw edge cycle t gives key_level=1 at t+2+DEBOUNCE_CYCLES, and key_press in the following cycle.
- Bounces shorter than DEBOUNCE_CYCLES produce no level change.
- step_en is registered: it asserts 1 cycle after its trigger.
- FSM states:
  - IDLE:
    - mode=SINGLE: a key_press[STEP_KEY] gives exactly one step_en.
    - mode=BURST: a key_press[STEP_KEY] moves to BURST, loading remaining = burst_len, with burst_len=0 treated as 1.
    - mode=RUN: moves to RUN and clears the divider.
    - mode=HALT: stays in IDLE.
  - BURST: step_en every cycle; remaining decrements on each pulse. Returns to IDLE after the last pulse. Exactly burst_len pulses on consecutive cycles.
    - Further presses are ignored.
    - mode changes to SINGLE/RUN take effect only after the burst completes.
    - mode=HALT aborts the burst; no further pulses from the next cycle on.
  - RUN: divider counts 0..run_div. step_en is issued when the divider wraps, so the period is run_div+1 cycles; run_div=0 gives step_en every cycle.
    - Any mode other than RUN returns to IDLE the next cycle, with no further pulses.
    - Key presses are ignored for stepping.
- busy = 1 in BURST and RUN.
- step_count increments on every step_en and wraps modulo 2^COUNT_W.
- A press arriving in the same cycle as the FSM returns to IDLE is dropped; the press must occur while in IDLE.

Decomposition:
- Shared package step_pkg:
  - mode encodings MODE_SINGLE/MODE_BURST/MODE_RUN/MODE_HALT;
  - FSM state typedef (IDLE, BURST, RUN);
  - default DEBOUNCE_CYCLES constant.
- One sub-module, key_debounce: single key, parametrised by DEBOUNCE_CYCLES. It contains the synchroniser, counter, level and press pulse, and is instantiated NUM_KEYS times via generate.
- FSM, burst counter, run divider and step_count live in step_controller.

Test Plan:
1. Reset behaviour: DEBOUNCE_CYCLES=4. Hold reset_n=0 for 3 cycles with key_n=4'b0000. Required: all outputs 0 throughout reset; key_level reaches 4'b1111 only at reset release +6 cycles; step_count=0.
2. Single step with bounce: mode=00. Press KEY0 with 2-cycle glitches, then hold low for 10 cycles. Required: exactly one key_press[0], exactly one step_en, step_count=1. The glitches alone produce no pulse.
3. Burst: mode=01, burst_len=5, one press. Required: 5 consecutive step_en, busy high for 5 cycles, step_count=5. A second press mid-burst adds no pulses. Repeat with burst_len=0: exactly 1 pulse.
4. Burst abort: burst_len=200, set mode=11 after the 10th pulse. Required: no step_en from the next cycle; busy=0; step_count=10.
5. Run: mode=10, run_div=3, run for 40 cycles. Required: step_en every 4th cycle, 10 pulses. Switch mode to 00: no further pulses from the next cycle on. Repeat with run_div=0: step_en every cycle.
6. Wrap and reset mid-run: COUNT_W=4, RUN with run_div=0 for 17 cycles. Required: step_count=1 after wrap. Assert reset_n=0 mid-run: step_en=0 and busy=0 on the next edge.

Source files
------------

// File: rtl/step_pkg.sv
// Shared definitions for the front-panel step controller.
//   - mode encodings driven on the mode input
//   - step FSM state type
//   - default debounce length (10 ms at 50 MHz)
package step_pkg;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_BURST  = 2'b01;
    localparam logic [1:0] MODE_RUN    = 2'b10;
    localparam logic [1:0] MODE_HALT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/step_controller_if.sv
// Front-panel bus between the board/testbench and step_controller.
//   master : drives raw keys and step configuration, observes key/step status
//   slave  : step_controller side
//   key_n      raw active-low buttons      key_level  debounced level, 1 = pressed
//   mode       SINGLE/BURST/RUN/HALT        key_press  one-cycle press pulse
//   burst_len  steps per BURST press        step_en    one-cycle CPU advance enable
//   run_div    RUN period minus 1           busy       burst or run in progress
//                                           step_count step_en pulses since reset
interface step_controller_if #(
    parameter int NUM_KEYS = 4,
    parameter int BURST_W  = 8,
    parameter int DIV_W    = 26,
    parameter int COUNT_W  = 16
);
    logic [NUM_KEYS-1:0] key_n;
    logic [1:0]          mode;
    logic [BURST_W-1:0]  burst_len;
    logic [DIV_W-1:0]    run_div;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic                step_en;
    logic                busy;
    logic [COUNT_W-1:0]  step_count;

    modport master (
        output key_n, mode, burst_len, run_div,
        input  key_level, key_press, step_en, busy, step_count
    );

    modport slave (
        input  key_n, mode, burst_len, run_div,
        output key_level, key_press, step_en, busy, step_count
    );
endinterface

// File: rtl/key_debounce.sv
// Single push-button conditioner: 2-flop synchroniser, debounce counter,
// debounced level and a one-cycle press pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   key_n      : raw asynchronous button, 0 = pressed
//   key_level  : debounced level, 1 = pressed
//   key_press  : pulse in the cycle after key_level rises
module key_debounce
    import step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;
    logic             press_q, press_d;

    always_comb begin
        sync1_d     = key_n;
        sync2_d     = sync1_q;
        cnt_d       = '0;
        level_d     = level_q;
        level_dly_d = level_q;
        // Any cycle where the synced key agrees with the level restarts the count.
        if (!sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Rising edge of the registered level, so the pulse trails level by one cycle.
        press_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
        end
    end

    assign key_level = level_q;
    assign key_press = press_q;
endmodule

// File: rtl/step_controller.sv
// Front-panel step/clock controller. Conditions NUM_KEYS buttons and issues a
// one-cycle CPU step enable in SINGLE, BURST, RUN or HALT mode.
//   CLOCK_50 : system clock
//   reset_n  : synchronous active-low reset
//   bus      : key inputs, mode/burst/run configuration, key and step status
module step_controller
    import step_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int STEP_KEY        = 0,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int BURST_W         = 8,
    parameter int DIV_W           = 26,
    parameter int COUNT_W         = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    step_controller_if.slave  bus
);
    logic [NUM_KEYS-1:0] key_n_w;
    logic [NUM_KEYS-1:0] key_level_w;
    logic [NUM_KEYS-1:0] key_press_w;

    assign key_n_w = bus.key_n;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk       (CLOCK_50),
            .rst_n     (reset_n),
            .key_n     (key_n_w[k]),
            .key_level (key_level_w[k]),
            .key_press (key_press_w[k])
        );
    end

    state_e             state_q, state_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               step_en_q, step_en_d;
    logic [COUNT_W-1:0] step_count_q, step_count_d;
    logic [BURST_W-1:0] burst_len_eff;
    logic               press_step;

    assign press_step    = key_press_w[STEP_KEY];
    assign burst_len_eff = (bus.burst_len == '0) ? BURST_W'(1) : bus.burst_len;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        div_d       = div_q;
        step_en_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                unique case (bus.mode)
                    MODE_SINGLE: step_en_d = press_step;
                    MODE_BURST: begin
                        if (press_step) begin
                            state_d     = BURST;
                            remaining_d = burst_len_eff;
                        end
                    end
                    MODE_RUN: begin
                        state_d = RUN;
                        div_d   = '0;
                    end
                    default: ;
                endcase
            end
            BURST: begin
                // Only HALT can cut a burst short; other modes wait for it to end.
                if (bus.mode == MODE_HALT) begin
                    state_d = IDLE;
                end else begin
                    step_en_d   = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == BURST_W'(1)) state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.mode != MODE_RUN) begin
                    state_d = IDLE;
                end else if (div_q >= bus.run_div) begin
                    // >= so a run_div lowered mid-run still wraps promptly.
                    step_en_d = 1'b1;
                    div_d     = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Count moves with the pulse itself, so step_count includes a visible step_en.
        step_count_d = step_count_q + COUNT_W'(step_en_d);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            div_q        <= '0;
            step_en_q    <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            div_q        <= div_d;
            step_en_q    <= step_en_d;
            step_count_q <= step_count_d;
        end
    end

    assign bus.key_level  = key_level_w;
    assign bus.key_press  = key_press_w;
    assign bus.step_en    = step_en_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.step_count = step_count_q;
endmodule

// File: tb/tb_step_controller.sv
// Scoreboard bench for step_controller: stimulus pushes the expected cycle and
// step_count of every step_en pulse; a negedge monitor pops and compares.
module tb_step_controller;
    import step_pkg::*;

    localparam int NK = 4;
    localparam int BW = 8;
    localparam int DW = 26;
    localparam int CW = 4;
    localparam int DB = 4;

    typedef struct {
        int            cyc;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    step_controller_if #(.NUM_KEYS(NK), .BURST_W(BW), .DIV_W(DW), .COUNT_W(CW)) sif ();

    step_controller #(
        .NUM_KEYS(NK), .STEP_KEY(0), .DEBOUNCE_CYCLES(DB),
        .BURST_W(BW), .DIV_W(DW), .COUNT_W(CW)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .bus      (sif)
    );

    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            press_cnt = 0;
    logic [CW-1:0] exp_cnt;
    exp_t          sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int at);
        exp_t e;
        exp_cnt = exp_cnt + 1'b1;
        e.cyc = at;
        e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    // Monitor: every step_en must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (sif.key_press[0] === 1'b1) press_cnt++;
        if (sif.step_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_step_en: got pulse at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("step_en_cycle", cyc, e.cyc);
                chk("step_count_at_pulse", 32'(sif.step_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        int e;
        int base;

        rst_n         = 1'b0;
        sif.key_n     = '0;
        sif.mode      = MODE_HALT;
        sif.burst_len = '0;
        sif.run_div   = '0;
        exp_cnt       = '0;

        // 1. reset with all keys held down
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_key_level", 32'(sif.key_level), 0);
            chk("rst_key_press", 32'(sif.key_press), 0);
            chk("rst_step_en", 32'(sif.step_en), 0);
            chk("rst_busy", 32'(sif.busy), 0);
            chk("rst_step_count", 32'(sif.step_count), 0);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk("key_level_settling", 32'(sif.key_level), 0);
        end
        tick(1);
        chk("key_level_release_plus6", 32'(sif.key_level), 32'hF);
        chk("step_count_after_reset", 32'(sif.step_count), 0);
        tick(1);
        chk("key_press_all", 32'(sif.key_press), 32'hF);
        tick(1);
        chk("key_press_one_cycle", 32'(sif.key_press), 0);
        sif.key_n = '1;
        tick(12);
        chk("key_level_released", 32'(sif.key_level), 0);

        // 2. single step with bounce
        sif.mode = MODE_SINGLE;
        base = press_cnt;
        sif.key_n[0] = 1'b0; tick(2);
        sif.key_n[0] = 1'b1; tick(2);
        sif.key_n[0] = 1'b0; tick(2);
        sif.key_n[0] = 1'b1; tick(3);
        chk("glitch_no_press", press_cnt, base);
        chk("glitch_no_level", 32'(sif.key_level), 0);
        e = cyc;
        sif.key_n[0] = 1'b0;
        expect_pulse(e + 8);
        tick(10);
        sif.key_n[0] = 1'b1;
        tick(12);
        chk("single_press_count", press_cnt, base + 1);
        chk("single_step_count", 32'(sif.step_count), 32'(exp_cnt));
        chk("single_pending", sb.size(), 0);

        // 3a. burst of 5
        sif.mode = MODE_BURST;
        sif.burst_len = 8'd5;
        e = cyc;
        sif.key_n[0] = 1'b0;
        for (int i = 0; i < 5; i++) expect_pulse(e + 9 + i);
        tick(8);
        for (int i = 0; i < 5; i++) begin
            chk("busy_in_burst", 32'(sif.busy), 1);
            tick(1);
        end
        chk("busy_after_burst", 32'(sif.busy), 0);
        sif.key_n[0] = 1'b1;
        tick(12);
        chk("burst5_step_count", 32'(sif.step_count), 32'(exp_cnt));
        chk("burst5_pending", sb.size(), 0);

        // 3b. burst_len = 0 behaves as 1
        sif.burst_len = 8'd0;
        e = cyc;
        sif.key_n[0] = 1'b0;
        expect_pulse(e + 9);
        tick(8);
        chk("busy_len0", 32'(sif.busy), 1);
        tick(1);
        chk("busy_len0_done", 32'(sif.busy), 0);
        sif.key_n[0] = 1'b1;
        tick(12);
        chk("burst0_pending", sb.size(), 0);

        // 3c. second press mid-burst is ignored
        sif.burst_len = 8'd20;
        base = press_cnt;
        e = cyc;
        sif.key_n[0] = 1'b0;
        for (int i = 0; i < 20; i++) expect_pulse(e + 9 + i);
        tick(7);
        sif.key_n[0] = 1'b1; tick(7);
        sif.key_n[0] = 1'b0; tick(7);
        sif.key_n[0] = 1'b1; tick(20);
        chk("midburst_two_presses", press_cnt, base + 2);
        chk("burst20_step_count", 32'(sif.step_count), 32'(exp_cnt));
        chk("burst20_pending", sb.size(), 0);

        // 4. HALT aborts a long burst after the 10th pulse
        sif.burst_len = 8'd200;
        e = cyc;
        sif.key_n[0] = 1'b0;
        for (int i = 0; i < 10; i++) expect_pulse(e + 9 + i);
        tick(18);
        sif.mode = MODE_HALT;
        sif.key_n[0] = 1'b1;
        tick(1);
        chk("abort_step_en", 32'(sif.step_en), 0);
        chk("abort_busy", 32'(sif.busy), 0);
        tick(1);
        chk("abort_step_count", 32'(sif.step_count), 32'(exp_cnt));
        tick(10);
        chk("abort_pending", sb.size(), 0);

        // 5. RUN with period 4, then leave RUN right before an 11th pulse
        sif.run_div = 26'd3;
        e = cyc;
        sif.mode = MODE_RUN;
        for (int k = 0; k < 10; k++) expect_pulse(e + 5 + 4 * k);
        tick(44);
        chk("run_busy", 32'(sif.busy), 1);
        sif.mode = MODE_SINGLE;
        tick(1);
        chk("run_exit_busy", 32'(sif.busy), 0);
        chk("run_exit_step_en", 32'(sif.step_en), 0);
        tick(8);
        chk("run_step_count", 32'(sif.step_count), 32'(exp_cnt));
        chk("run_pending", sb.size(), 0);

        // 6. RUN every cycle across the 4-bit wrap, then reset mid-run
        rst_n = 1'b0;
        exp_cnt = '0;
        tick(3);
        chk("rerst_step_count", 32'(sif.step_count), 0);
        rst_n = 1'b1;
        sif.run_div = '0;
        tick(2);
        e = cyc;
        sif.mode = MODE_RUN;
        for (int i = 0; i < 17; i++) expect_pulse(e + 2 + i);
        tick(18);
        chk("count_after_wrap", 32'(sif.step_count), 1);
        chk("wrap_busy", 32'(sif.busy), 1);
        rst_n = 1'b0;
        tick(1);
        chk("midrun_rst_step_en", 32'(sif.step_en), 0);
        chk("midrun_rst_busy", 32'(sif.busy), 0);
        chk("midrun_rst_count", 32'(sif.step_count), 0);
        exp_cnt = '0;
        tick(2);
        chk("final_pending", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
